// File: rtl/mips_isa_pkg.sv
// Opcode map, op-class codes, field positions and encoder FSM states shared by
// the instruction encoder and the pipeline control decode.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] CLS_R    = 3'd0;
  localparam logic [2:0] CLS_LW   = 3'd1;
  localparam logic [2:0] CLS_SW   = 3'd2;
  localparam logic [2:0] CLS_BEQ  = 3'd3;
  localparam logic [2:0] CLS_ADDI = 3'd4;
  localparam logic [2:0] CLS_J    = 3'd5;
  localparam logic [2:0] CLS_ILL6 = 3'd6;
  localparam logic [2:0] CLS_ILL7 = 3'd7;

  localparam int OPC_LSB    = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } enc_state_e;

  function automatic logic cls_legal(input logic [2:0] cls);
    return cls <= CLS_J;
  endfunction

  function automatic logic [31:0] encode(
    input logic [2:0]  cls,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    w = '0;
    case (cls)
      CLS_R: begin
        w[OPC_LSB +: 6]   = OP_RTYPE;
        w[RS_LSB +: 5]    = rs;
        w[RT_LSB +: 5]    = rt;
        w[RD_LSB +: 5]    = rd;
        w[SHAMT_LSB +: 5] = 5'd0;
        w[FUNCT_LSB +: 6] = funct;
      end
      CLS_LW, CLS_SW, CLS_BEQ, CLS_ADDI: begin
        case (cls)
          CLS_LW:  w[OPC_LSB +: 6] = OP_LW;
          CLS_SW:  w[OPC_LSB +: 6] = OP_SW;
          CLS_BEQ: w[OPC_LSB +: 6] = OP_BEQ;
          default: w[OPC_LSB +: 6] = OP_ADDI;
        endcase
        w[RS_LSB +: 5]   = rs;
        w[RT_LSB +: 5]   = rt;
        w[IMM_LSB +: 16] = imm;
      end
      CLS_J: begin
        w[OPC_LSB +: 6]     = OP_J;
        w[TARGET_LSB +: 26] = target;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Instruction-field input handshake plus the instruction-memory write port.
interface mips_instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              in_last;
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_target, in_last,
    input  in_ready,
    input  wr_en, wr_addr, wr_data,
    output wr_ready
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_target, in_last,
    output in_ready,
    output wr_en, wr_addr, wr_data,
    input  wr_ready
  );
endinterface

// File: rtl/enc_fifo.sv
// Synchronous FIFO for encoded words; head is visible combinationally so a
// word pushed at edge t is presented to memory in cycle t+1.
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/mips_instr_encoder.sv
// Packs symbolic instructions into MIPS words and streams them into memory.
// Optional ENC_HALT_APPEND_EN appends a self-jump halt word after the program.
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  mips_instr_encoder_if.slave bus,
  output logic               busy,
  output logic               done,
  output logic               err_illegal,
  output logic               err_overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_illegal_q, err_illegal_d;
  logic              err_overflow_q, err_overflow_d;
  logic              in_ready, accept, wr_done;
  logic              push, flush, fifo_full, fifo_empty;
  logic [31:0]       enc_word, push_data, fifo_head;
  logic [CW-1:0]     fifo_count;

  assign enc_word = encode(bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd,
                           bus.in_funct, bus.in_imm, bus.in_target);
  assign accept   = bus.in_valid && in_ready;
  assign wr_done  = !fifo_empty && bus.wr_ready;

`ifdef ENC_HALT_APPEND_EN
  logic        halt_pend_q, halt_pend_d;
  logic [25:0] halt_tgt;
  // The halt lands behind every word still queued, including one popping now.
  assign halt_tgt = 26'(addr_q) + 26'(fifo_count);
`else
  wire unused_count = ^fifo_count;
`endif

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    err_illegal_d  = err_illegal_q;
    err_overflow_d = err_overflow_q;
    in_ready       = 1'b0;
    push           = 1'b0;
    push_data      = enc_word;
    flush          = 1'b0;
`ifdef ENC_HALT_APPEND_EN
    halt_pend_d    = halt_pend_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d        = ST_LOAD;
          addr_d         = base_addr;
          err_illegal_d  = 1'b0;
          err_overflow_d = 1'b0;
        end
      end
      ST_LOAD: begin
        in_ready = !fifo_full && !err_overflow_q;
        if (accept) begin
          if (cls_legal(bus.in_op)) push = 1'b1;
          else                      err_illegal_d = 1'b1;
          if (bus.in_last) begin
            state_d = ST_DRAIN;
`ifdef ENC_HALT_APPEND_EN
            halt_pend_d = 1'b1;
`endif
          end
        end
      end
      ST_DRAIN: begin
`ifdef ENC_HALT_APPEND_EN
        if (halt_pend_q) begin
          if (!fifo_full) begin
            push        = 1'b1;
            push_data   = {OP_J, halt_tgt};
            halt_pend_d = 1'b0;
          end
        end else if (fifo_empty) begin
          state_d = ST_DONE;
        end
`else
        if (fifo_empty) state_d = ST_DONE;
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A write at the top address ends the load: address holds, queue discarded.
    if (wr_done) begin
      if (addr_q == ADDR_MAX) begin
        err_overflow_d = 1'b1;
        flush          = 1'b1;
        push           = 1'b0;
        state_d        = ST_DRAIN;
`ifdef ENC_HALT_APPEND_EN
        halt_pend_d    = 1'b0;
`endif
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      err_illegal_q  <= 1'b0;
      err_overflow_q <= 1'b0;
`ifdef ENC_HALT_APPEND_EN
      halt_pend_q    <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      err_illegal_q  <= err_illegal_d;
      err_overflow_q <= err_overflow_d;
`ifdef ENC_HALT_APPEND_EN
      halt_pend_q    <= halt_pend_d;
`endif
    end
  end

  enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (wr_done),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.in_ready  = in_ready;
  assign bus.wr_en     = !fifo_empty;
  assign bus.wr_addr   = addr_q;
  assign bus.wr_data   = fifo_head;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign err_illegal   = err_illegal_q;
  assign err_overflow  = err_overflow_q;
endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder: encoding, back-pressure, illegal ops,
// address overflow, reset mid-load and (when enabled) the appended halt word.
module tb_mips_instr_encoder;

`ifdef ENC_HALT_APPEND_EN
  localparam int HALT_N = 1;
`else
  localparam int HALT_N = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] base_addr;
  logic       busy, done, err_illegal, err_overflow;

  always #5 clk = ~clk;

  mips_instr_encoder_if #(.ADDR_W(8)) bus ();

  mips_instr_encoder #(
    .ADDR_W     (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .err_illegal  (err_illegal),
    .err_overflow (err_overflow)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [7:0]  wa_q [$];
  logic [31:0] wd_q [$];
  int          wc_q [$];
  int          dc_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Log completed writes and done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    #1;
    if (!reset && bus.wr_en && bus.wr_ready) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
      wc_q.push_back(cyc);
      $display("write addr=%02h data=%08h cycle=%0d", bus.wr_addr, bus.wr_data, cyc);
    end
    if (!reset && done) dc_q.push_back(cyc);
  end

  task automatic clear_logs();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    dc_q.delete();
  endtask

  task automatic do_start(input logic [7:0] b);
    base_addr = b;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic last, input int budget,
                      output bit ok);
    ok            = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_rs     = rs;
    bus.in_rt     = rt;
    bus.in_rd     = rd;
    bus.in_funct  = funct;
    bus.in_imm    = imm;
    bus.in_target = tgt;
    bus.in_last   = last;
    for (int i = 0; i < budget; i++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    $display("send op=%0d last=%0b accepted=%0b", op, last, ok);
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s done_timeout: got no done within %0d cycles, required done pulse", name, budget);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, err_illegal, err_overflow, bus.in_ready, bus.wr_en} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %06b required 000000",
               {busy, done, err_illegal, err_overflow, bus.in_ready, bus.wr_en});
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, bus.in_ready, bus.wr_en, bus.wr_addr} !== 11'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got busy=%b in_ready=%b wr_en=%b addr=%02h required all 0",
               busy, bus.in_ready, bus.wr_en, bus.wr_addr);
    end
  endtask

  task automatic test_single_addi();
    bit ok;
    clear_logs();
    do_start(8'h10);
    // Unused rd/funct/target carry garbage that must not reach the word.
    send(3'd4, 5'd0, 5'd1, 5'h1F, 6'h3F, 16'h0005, 26'h3FFFFFF, 1'b1, 20, ok);
    wait_done("single", 40);
    vectors++;
    if (wa_q.size() != 1 + HALT_N) begin
      miscompares++;
      $display("FAIL single_count: got %0d writes required %0d", wa_q.size(), 1 + HALT_N);
    end else begin
      vectors++;
      if (wa_q[0] !== 8'h10 || wd_q[0] !== 32'h20010005) begin
        miscompares++;
        $display("FAIL single_word: got %02h/%08h required 10/20010005", wa_q[0], wd_q[0]);
      end
`ifndef ENC_HALT_APPEND_EN
      vectors++;
      if (dc_q.size() != 1 || dc_q[0] - wc_q[0] != 2) begin
        miscompares++;
        $display("FAIL single_done_latency: got %0d done pulses, gap %0d required 1 pulse gap 2",
                 dc_q.size(), (dc_q.size() > 0) ? dc_q[0] - wc_q[0] : -1);
      end
`endif
    end
    vectors++;
    if ({err_illegal, err_overflow, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL single_flags: got ill=%b ovf=%b busy=%b required 0 0 0",
               err_illegal, err_overflow, busy);
    end
  endtask

  task automatic test_multi();
    bit ok;
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h00221820;
    exp_d[1] = 32'h8C040008;
    exp_d[2] = 32'h08000040;
    clear_logs();
    do_start(8'h30);
    send(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'hFFFF, 26'h0, 1'b0, 20, ok);
    send(3'd1, 5'd0, 5'd4, 5'd9, 6'h11, 16'h0008, 26'h0, 1'b0, 20, ok);
    send(3'd5, 5'd7, 5'd7, 5'd7, 6'h3F, 16'hABCD, 26'h40, 1'b1, 20, ok);
    wait_done("multi", 40);
    vectors++;
    if (wa_q.size() != 3 + HALT_N) begin
      miscompares++;
      $display("FAIL multi_count: got %0d writes required %0d", wa_q.size(), 3 + HALT_N);
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (wa_q[i] !== 8'(8'h30 + i) || wd_q[i] !== exp_d[i]) begin
          miscompares++;
          $display("FAIL multi_word%0d: got %02h/%08h required %02h/%08h",
                   i, wa_q[i], wd_q[i], 8'(8'h30 + i), exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] exp_d [5];
    exp_d[0] = 32'h20010001;
    exp_d[1] = 32'h20020002;
    exp_d[2] = 32'h20030003;
    exp_d[3] = 32'h20040004;
    exp_d[4] = 32'h20050005;
    clear_logs();
    bus.wr_ready = 1'b0;
    do_start(8'h40);
    for (int i = 1; i <= 4; i++)
      send(3'd4, 5'd0, 5'(i), 5'd0, 6'd0, 16'(i), 26'd0, 1'b0, 20, ok);
    vectors++;
    if ({bus.in_ready, bus.wr_en, bus.wr_addr} !== {1'b0, 1'b1, 8'h40}) begin
      miscompares++;
      $display("FAIL bp_full: got in_ready=%b wr_en=%b addr=%02h required 0 1 40",
               bus.in_ready, bus.wr_en, bus.wr_addr);
    end
    bus.wr_ready = 1'b1;
    send(3'd4, 5'd0, 5'd5, 5'd0, 6'd0, 16'd5, 26'd0, 1'b1, 20, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL bp_fifth_accept: got not accepted required accepted");
    end
    wait_done("backpressure", 60);
    vectors++;
    if (wa_q.size() != 5 + HALT_N) begin
      miscompares++;
      $display("FAIL bp_count: got %0d writes required %0d", wa_q.size(), 5 + HALT_N);
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (wa_q[i] !== 8'(8'h40 + i) || wd_q[i] !== exp_d[i]) begin
          miscompares++;
          $display("FAIL bp_word%0d: got %02h/%08h required %02h/%08h",
                   i, wa_q[i], wd_q[i], 8'(8'h40 + i), exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_illegal();
    bit ok;
    clear_logs();
    do_start(8'h50);
    send(3'd7, 5'd1, 5'd2, 5'd3, 6'h20, 16'h1234, 26'h55, 1'b0, 20, ok);
    do_start(8'h99);
    vectors++;
    if ({err_illegal, bus.wr_en, bus.wr_addr} !== {1'b1, 1'b0, 8'h50} || wa_q.size() != 0) begin
      miscompares++;
      $display("FAIL illegal_state: got ill=%b wr_en=%b addr=%02h writes=%0d required 1 0 50 0",
               err_illegal, bus.wr_en, bus.wr_addr, wa_q.size());
    end
    send(3'd2, 5'd2, 5'd3, 5'd0, 6'd0, 16'hFFFC, 26'd0, 1'b1, 20, ok);
    wait_done("illegal", 40);
    vectors++;
    if (wa_q.size() < 1 || wa_q[0] !== 8'h50 || wd_q[0] !== 32'hAC43FFFC) begin
      miscompares++;
      $display("FAIL illegal_next_word: got %0d writes first %02h/%08h required 50/AC43FFFC",
               wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : 8'h00, (wd_q.size() > 0) ? wd_q[0] : 32'h0);
    end
    vectors++;
    if (err_illegal !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_sticky: got %b required 1", err_illegal);
    end
    do_start(8'h60);
    vectors++;
    if (err_illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_clear_on_start: got %b required 0", err_illegal);
    end
    send(3'd4, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1, 20, ok);
    wait_done("illegal_cleanup", 40);
  endtask

  task automatic test_overflow();
    bit ok;
    clear_logs();
    do_start(8'hFE);
    send(3'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b0, 20, ok);
    send(3'd4, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0002, 26'd0, 1'b0, 20, ok);
    send(3'd4, 5'd0, 5'd3, 5'd0, 6'd0, 16'h0003, 26'd0, 1'b1, 5, ok);
    wait_done("overflow", 40);
    vectors++;
    if (wa_q.size() != 2) begin
      miscompares++;
      $display("FAIL ovf_count: got %0d writes required 2", wa_q.size());
    end else begin
      vectors++;
      if (wa_q[0] !== 8'hFE || wd_q[0] !== 32'h20010001 ||
          wa_q[1] !== 8'hFF || wd_q[1] !== 32'h20020002) begin
        miscompares++;
        $display("FAIL ovf_words: got %02h/%08h %02h/%08h required FE/20010001 FF/20020002",
                 wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
      end
    end
    vectors++;
    if ({err_overflow, bus.wr_addr, busy} !== {1'b1, 8'hFF, 1'b0}) begin
      miscompares++;
      $display("FAIL ovf_flags: got ovf=%b addr=%02h busy=%b required 1 FF 0",
               err_overflow, bus.wr_addr, busy);
    end
  endtask

  task automatic test_reset_midload();
    bit ok;
    clear_logs();
    bus.wr_ready = 1'b0;
    do_start(8'h70);
    send(3'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b0, 20, ok);
    send(3'd4, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0002, 26'd0, 1'b0, 20, ok);
    reset        = 1'b1;
    bus.wr_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if ({bus.wr_en, busy, bus.in_ready, err_overflow} !== 4'b0) begin
      miscompares++;
      $display("FAIL midload_reset: got wr_en=%b busy=%b in_ready=%b ovf=%b required 0 0 0 0",
               bus.wr_en, busy, bus.in_ready, err_overflow);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (wa_q.size() != 0 || bus.wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL midload_no_writes: got %0d writes wr_en=%b required 0 0", wa_q.size(), bus.wr_en);
    end
  endtask

`ifdef ENC_HALT_APPEND_EN
  task automatic test_halt_append();
    bit ok;
    clear_logs();
    do_start(8'h20);
    send(3'd3, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0003, 26'd0, 1'b1, 20, ok);
    wait_done("halt", 40);
    vectors++;
    if (wa_q.size() != 2 || wa_q[0] !== 8'h20 || wd_q[0] !== 32'h10220003 ||
        wa_q[1] !== 8'h21 || wd_q[1] !== 32'h08000021) begin
      miscompares++;
      $display("FAIL halt_words: got %0d writes required 20/10220003 21/08000021", wa_q.size());
    end
  endtask
`endif

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    base_addr     = 8'h00;
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'd0;
    bus.in_rs     = 5'd0;
    bus.in_rt     = 5'd0;
    bus.in_rd     = 5'd0;
    bus.in_funct  = 6'd0;
    bus.in_imm    = 16'd0;
    bus.in_target = 26'd0;
    bus.in_last   = 1'b0;
    bus.wr_ready  = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_addi();
    test_multi();
    test_backpressure();
    test_illegal();
    test_overflow();
    test_reset_midload();
`ifdef ENC_HALT_APPEND_EN
    test_halt_append();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
Encoder side of the opcode/control-decode interface. Accepts symbolic instruction descriptions (op class plus fields) over a valid/ready handshake. Packs each one into a 32-bit MIPS word using the same opcode map the pipeline decoder consumes, buffers it, and writes it sequentially into instruction memory. Used by the program loader and by testbenches to build instruction streams.

Parameters:
ADDR_W, 8, instruction-memory word-address width
FIFO_DEPTH, 4, encoded-word buffer entries (power of two, >= 2)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse: begin a new program load at base_addr
base_addr  in  ADDR_W  first word address of the load
in_valid  in  1  instruction fields valid
in_ready  out  1  encoder can accept this cycle
in_op  in  3  op class: 0 R, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J, 6-7 illegal
in_rs, in_rt, in_rd  in  5 each  register fields
in_funct  in  6  R-type funct
in_imm  in  16  I-type immediate
in_target  in  26  J-type target
in_last  in  1  final instruction of the program
wr_en  out  1  memory write strobe
wr_ready  in  1  memory accepts the write this cycle
wr_addr  out  ADDR_W  word address
wr_data  out  32  encoded instruction
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of load
err_illegal  out  1  sticky: an illegal op was received
err_overflow  out  1  sticky: address space exhausted

Behaviour:
- Reset: state IDLE, FIFO empty, addr 0. All outputs 0 except in_ready, which is also 0.
- Encoding, with opcode values 000000/100011/101011/000100/001000/000010:
  - R: {000000, rs, rt, rd, 00000, funct}
  - LW/SW/BEQ/ADDI: {op, rs, rt, imm}
  - J: {000010, target}
  - Fields unused by the class are ignored.
- FSM states IDLE, LOAD, DRAIN, DONE.
  - IDLE: start -> LOAD; addr <= base_addr; error flags cleared.
  - LOAD: in_ready = !fifo_full && !ovf_lock. An accept (in_valid && in_ready) pushes the encoded word at that clock edge.
    - Accept with in_last -> DRAIN.
    - Illegal op: accepted but not pushed; sets err_illegal. If in_last is also set, still -> DRAIN.
  - DRAIN: in_ready = 0; wait for FIFO empty -> DONE.
  - DONE: done = 1 for one cycle -> IDLE.
- Write port:
  - wr_en = FIFO non-empty; wr_data = FIFO head; wr_addr = addr.
  - Write completes when wr_en && wr_ready: pop the head, addr++.
  - Minimum latency: accept at edge t -> wr_en high in cycle t+1.
- Simultaneous push and pop when full: not allowed, because in_ready is already 0. Push and pop in the same cycle when not full is allowed; the count is unchanged.
- Address boundary: a completed write at addr = 2^ADDR_W-1 sets err_overflow and ovf_lock. addr holds and does not wrap. The FIFO is flushed (remaining words discarded) and the FSM goes to DRAIN -> DONE.
- start is ignored outside IDLE.
- reset mid-load: immediate return to IDLE, FIFO cleared, no further wr_en.

Optional Feature:
ENC_HALT_APPEND_EN
- Defined: on entering DRAIN, the block pushes one extra word, a self-jump halt. Its target is the zero-extended word address it will occupy, i.e. the address after the last real instruction. If the FIFO is full, the push waits. If ovf_lock is set, the halt is skipped.
- Undefined: no halt word is appended; DRAIN only empties the FIFO.

Decomposition:
- Package mips_isa_pkg:
  - opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - op-class encoding constants 0-7
  - field bit-position constants
  - FSM state typedef
- Shared between this block and the pipeline's control decode.
- One natural sub-module: enc_fifo, a synchronous FIFO of FIFO_DEPTH x 32 with full/empty/count.

Test Plan:
- Reset, then start with base_addr=0x10; push ADDI rs=0 rt=1 imm=5 with last -> one write: addr 0x10, data 0x20010005. done pulses 2 cycles after the write; err flags stay 0.
- Push R (rs=1 rt=2 rd=3 funct=0x20), LW (rs=0 rt=4 imm=8), J (target 0x40, last) -> data 0x00221820, 0x8C040008, 0x08000040 at consecutive addresses.
- Hold wr_ready=0 while pushing 5 instructions (FIFO_DEPTH=4) -> in_ready drops after the 4th accept. Release wr_ready -> all 5 written in order, none lost or duplicated.
- in_op=7 -> err_illegal=1, no write, addr unchanged. The following valid instruction is written normally.
- base_addr=0xFE, push 3 instructions -> writes at 0xFE and 0xFF, err_overflow=1, third word not written, done pulses.
- With ENC_HALT_APPEND_EN: base 0x20, one BEQ with last -> writes 0x20 (BEQ) and 0x21 with data 0x08000021.
